// File: rtl/chan_ctrl_pkg.sv
// Shared types for the channelizer control sequencer: FSM state encoding and
// config-word bit positions used by chan_ctrl_seq and its size decoder.
package chan_ctrl_pkg;

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_WAIT = 2'd1,
        S_CFG  = 2'd2,
        S_RUN  = 2'd3
    } state_e;

    localparam int NFFT_LSB    = 0;
    localparam int NFFT_BITS   = 5;
    localparam int FWD_INV_BIT = 8;

endpackage

// File: rtl/chan_size_decode.sv
// Purpose: combinational fft_size -> {legal, log2}; legal = power of two in [MIN_LOG2, MAX_LOG2].
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Zero or non-power-of-two sizes decode as illegal with log2 = 0.
module chan_size_decode #(
    parameter int FFT_SIZE_WIDTH = 12,
    parameter int MIN_LOG2       = 3,
    parameter int MAX_LOG2       = 11
) (
    input  logic [FFT_SIZE_WIDTH-1:0] size_i,
    output logic                      legal_o,
    output logic [4:0]                log2_o
);

    always_comb begin
        legal_o = 1'b0;
        log2_o  = 5'd0;
        // Exactly one bit set means power of two; its index is the log2.
        for (int i = 0; i < FFT_SIZE_WIDTH; i++) begin
            if (size_i == (FFT_SIZE_WIDTH'(1) << i)) begin
                log2_o  = 5'(i);
                legal_o = (i >= MIN_LOG2) && (i <= MAX_LOG2);
            end
        end
    end

endmodule

// File: rtl/chan_ctrl_seq.sv
// Purpose: validate/latch fft_size, stretch datapath reset, sequence FFT aresetn and config beat.
// Latency: reset release to pipe_reset low = RESET_CYCLES+FFT_WAIT+1 cycles (cfg_tready high).
// Backpressure: config beat held until cfg_tready; datapath stays in reset meanwhile.
// Optional: define CHAN_CTRL_ERR_CNT_EN to add a saturating err_cnt output.
module chan_ctrl_seq
    import chan_ctrl_pkg::*;
#(
    parameter int FFT_SIZE_WIDTH = 12,
    parameter int MIN_LOG2       = 3,
    parameter int MAX_LOG2       = 11,
    parameter int DEFAULT_LOG2   = 7,
    parameter int RESET_CYCLES   = 8,
    parameter int FFT_WAIT       = 2,
    parameter int CFG_WIDTH      = 16,
    parameter int FWD_INV        = 1
) (
    input  logic                      clk,
    input  logic                      sync_reset,
    input  logic [FFT_SIZE_WIDTH-1:0] fft_size,
    output logic [FFT_SIZE_WIDTH-1:0] fft_size_out,
    output logic [4:0]                nfft_out,
    output logic                      pipe_reset,
    output logic                      fft_aresetn,
    output logic                      cfg_tvalid,
    output logic [CFG_WIDTH-1:0]      cfg_tdata,
    input  logic                      cfg_tready,
    output logic                      running,
`ifdef CHAN_CTRL_ERR_CNT_EN
    output logic [7:0]                err_cnt,
`endif
    output logic                      size_err
);

    localparam int CNT_MAX = (RESET_CYCLES > FFT_WAIT) ? RESET_CYCLES : FFT_WAIT;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]          HOLD_INIT    = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]          WAIT_INIT    = CNT_W'(FFT_WAIT - 1);
    localparam logic [FFT_SIZE_WIDTH-1:0] DEFAULT_SIZE = FFT_SIZE_WIDTH'(1) << DEFAULT_LOG2;
    localparam logic [4:0]                DEFAULT_NFFT = 5'(DEFAULT_LOG2);

    function automatic logic [CFG_WIDTH-1:0] cfg_word(input logic [4:0] nfft);
        logic [CFG_WIDTH-1:0] w;
        w                          = '0;
        w[NFFT_LSB +: NFFT_BITS]   = nfft;
        w[FWD_INV_BIT]             = 1'(FWD_INV);
        return w;
    endfunction

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [FFT_SIZE_WIDTH-1:0]   size_q, size_d;
    logic [4:0]                  nfft_q, nfft_d;
    logic [FFT_SIZE_WIDTH-1:0]   rej_q, rej_d;
    logic                        err_d;
    logic                        change;

    logic                        pipe_reset_q;
    logic                        aresetn_q;
    logic                        cfg_tvalid_q;
    logic [CFG_WIDTH-1:0]        cfg_tdata_q;
    logic                        running_q;
    logic                        size_err_q;

    logic                        dec_legal;
    logic [4:0]                  dec_log2;

    chan_size_decode #(
        .FFT_SIZE_WIDTH (FFT_SIZE_WIDTH),
        .MIN_LOG2       (MIN_LOG2),
        .MAX_LOG2       (MAX_LOG2)
    ) u_size_decode (
        .size_i  (fft_size),
        .legal_o (dec_legal),
        .log2_o  (dec_log2)
    );

    assign change = (fft_size != '0) && (fft_size != size_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        nfft_d  = nfft_q;
        rej_d   = rej_q;
        err_d   = 1'b0;

        case (state_q)
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_WAIT;
                    cnt_d   = WAIT_INIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_CFG;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_CFG: begin
                if (cfg_tvalid_q && cfg_tready) begin
                    state_d = S_RUN;
                end
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = S_HOLD;
        endcase

        // A legal new size overrides any in-flight step, including a same-cycle config accept.
        if (change) begin
            if (dec_legal) begin
                size_d  = fft_size;
                nfft_d  = dec_log2;
                state_d = S_HOLD;
                cnt_d   = HOLD_INIT;
                rej_d   = '0;
            end else if (fft_size != rej_q) begin
                err_d = 1'b1;
                rej_d = fft_size;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q      <= S_HOLD;
            cnt_q        <= HOLD_INIT;
            size_q       <= DEFAULT_SIZE;
            nfft_q       <= DEFAULT_NFFT;
            rej_q        <= '0;
            pipe_reset_q <= 1'b1;
            aresetn_q    <= 1'b0;
            cfg_tvalid_q <= 1'b0;
            cfg_tdata_q  <= cfg_word(DEFAULT_NFFT);
            running_q    <= 1'b0;
            size_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            size_q       <= size_d;
            nfft_q       <= nfft_d;
            rej_q        <= rej_d;
            pipe_reset_q <= (state_d != S_RUN);
            aresetn_q    <= (state_d != S_HOLD);
            cfg_tvalid_q <= (state_d == S_CFG);
            cfg_tdata_q  <= cfg_word(nfft_d);
            running_q    <= (state_d == S_RUN);
            size_err_q   <= err_d;
        end
    end

`ifdef CHAN_CTRL_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            err_cnt_q <= 8'd0;
        end else if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign fft_size_out = size_q;
    assign nfft_out     = nfft_q;
    assign pipe_reset   = pipe_reset_q;
    assign fft_aresetn  = aresetn_q;
    assign cfg_tvalid   = cfg_tvalid_q;
    assign cfg_tdata    = cfg_tdata_q;
    assign running      = running_q;
    assign size_err     = size_err_q;

endmodule
